bat_fetch_sequencer: RTL and testbench
======================================

# bat_fetch_sequencer

Instruction-fetch control stage for the Bat Amateur processor. It drives the ENABLE/RW/COUNT strobes of the bus registers (PC, MAR, IR, operand register) and the memory port, so that each instruction word and optional operand word moves across the shared 16-bit data bus. It then presents the fetched instruction to the execute controller through a valid/done handshake. It sits directly upstream of the bus registers: every register strobe in the fetch path originates here.

## Interface
- BUS_WIDTH, 16, width of IR_OUTPUT.
- OPERAND_BIT, 15, bit index of IR_OUTPUT that flags a following operand word.
- MEM_TIMEOUT, 15, maximum wait cycles for MEM_READY before fault; legal range 1..255.

- CLOCK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low.
- HALT  in  1  when high, the sequencer stops at the next instruction boundary.
- MEM_READY  in  1  memory data valid on the bus this cycle.
- EXEC_DONE  in  1  execute controller has finished the current instruction.
- IR_OUTPUT  in  BUS_WIDTH  constant output of the instruction register.
- PC_ENABLE, PC_RW, PC_COUNT  out  1 each  program counter strobes.
- MAR_ENABLE, MAR_RW  out  1 each  memory address register strobes.
- MEM_ENABLE, MEM_RW  out  1 each  memory port strobes.
- IR_ENABLE, IR_RW  out  1 each  instruction register strobes.
- OPR_ENABLE, OPR_RW  out  1 each  operand register strobes.
- INSTR_VALID  out  1  IR (and OPR if flagged) hold a complete instruction.
- FAULT  out  1  memory timeout; sticky until reset.
- STATE  out  4  current state encoding, for debug.

## Operation
- Register strobe semantics: ENABLE=1 with RW=1 means the unit drives the bus. ENABLE=1 with RW=0 means the unit captures the bus on the clock edge. COUNT increments only when the unit is not capturing.
- At most one driver per cycle. Every strobe not listed for a state is 0.
- States:
  - HALTED: all strobes 0. Leave to ADDR when HALT=0.
  - ADDR: PC_ENABLE=1, PC_RW=1, MAR_ENABLE=1, MAR_RW=0. Always go to READ.
  - READ: MEM_ENABLE=1, MEM_RW=1. When MEM_READY=1, also IR_ENABLE=1, IR_RW=0 and PC_COUNT=1 in the same cycle, then go to DECODE. When MEM_READY=0, stay in READ.
  - DECODE: no strobes. If IR_OUTPUT[OPERAND_BIT]=1 go to OP_ADDR, else go to EXEC.
  - OP_ADDR: same strobes as ADDR. Always go to OP_READ.
  - OP_READ: same as READ, except the capture goes to OPR_ENABLE/OPR_RW instead of IR. On MEM_READY go to EXEC.
  - EXEC: INSTR_VALID=1. When EXEC_DONE=1, go to HALTED if HALT=1, else go to ADDR.
  - FAULT_ST: all strobes 0, FAULT=1. Only RESET exits.
- Wait timer: counts consecutive READ/OP_READ cycles with MEM_READY=0. When the count reaches MEM_TIMEOUT, the next state is FAULT_ST. The count clears on every state entry.
- HALT is sampled only in HALTED and at EXEC exit. A fetch in progress always completes.
- EXEC_DONE outside EXEC is ignored.

## Timing
- Strobes are Moore-decoded from the state register. The READ/OP_READ capture and count strobes are additionally gated combinationally by MEM_READY.
- Reset (RESET=0 at an edge): state becomes HALTED, timer 0, FAULT 0. All outputs are 0 in the following cycle. Reset mid-fetch abandons the fetch with no further strobes.
- Zero-wait fetch without operand: ADDR at cycle 0, READ at 1, DECODE at 2, INSTR_VALID=1 from cycle 3.
- Zero-wait fetch with operand: INSTR_VALID=1 from cycle 5.
- Each MEM_READY=0 cycle adds one cycle of latency.
- The cycle in which EXEC_DONE=1 is the last INSTR_VALID cycle. With HALT=0, ADDR follows immediately, giving a back-to-back fetch with no idle cycle.
- Timeout: with MEM_TIMEOUT=N and MEM_READY held low, READ lasts N+1 cycles and FAULT=1 on the next cycle.

## Structure
- Shared include bat_fetch_defs.vh holds:
  - the state encodings (HALTED=0, ADDR=1, READ=2, DECODE=3, OP_ADDR=4, OP_READ=5, EXEC=6, FAULT_ST=7);
  - the strobe polarity constants BUS_DRIVE=1 and BUS_LOAD=0.
- One sub-module, bat_wait_timer: 8-bit saturating counter with clear and increment inputs and an expired output compared against MEM_TIMEOUT.

## Test plan
- Reset, then HALT=0, MEM_READY=1, IR_OUTPUT=16'h0012, EXEC_DONE pulsed at cycle 5 -> strobe sequence ADDR, READ, DECODE, EXEC; PC_COUNT=1 exactly once (cycle 1); INSTR_VALID high in cycles 3-5; ADDR again at cycle 6.
- IR_OUTPUT=16'h8012, zero wait -> OP_ADDR at cycle 3; OPR_ENABLE=1 with OPR_RW=0 and PC_COUNT=1 at cycle 4; INSTR_VALID from cycle 5.
- MEM_READY low for 3 cycles in READ -> IR_ENABLE not asserted until the fourth READ cycle; INSTR_VALID from cycle 6.
- MEM_TIMEOUT=4, MEM_READY held 0 -> READ lasts 5 cycles, then FAULT=1 with all strobes 0; stays faulted until RESET=0.
- HALT raised during READ -> fetch completes; after EXEC_DONE, state is HALTED with all strobes 0; HALT=0 -> ADDR on the next cycle.
- RESET=0 during OP_READ -> the next cycle shows HALTED, INSTR_VALID=0 and no bus driver; the bus-contention checker reports zero overlapping drivers over the whole run.

Source files
------------

// File: rtl/bat_fetch_sequencer_pkg.sv
// Shared definitions for the Bat Amateur fetch sequencer.
// State encodings, bus strobe polarities and a state helper.
package bat_fetch_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_HALTED  = 4'd0,
    ST_ADDR    = 4'd1,
    ST_READ    = 4'd2,
    ST_DECODE  = 4'd3,
    ST_OP_ADDR = 4'd4,
    ST_OP_READ = 4'd5,
    ST_EXEC    = 4'd6,
    ST_FAULT   = 4'd7
  } state_e;

  localparam logic BUS_DRIVE = 1'b1;
  localparam logic BUS_LOAD  = 1'b0;

  localparam int unsigned TIMER_W = 8;

  function automatic logic is_read(input state_e s);
    return (s == ST_READ) || (s == ST_OP_READ);
  endfunction

endpackage

// File: rtl/bat_fetch_sequencer_if.sv
// Fetch-path bundle: control inputs, register/memory strobes, status.
// master = sequencer side, slave = bus registers / execute side.
interface bat_fetch_sequencer_if #(
  parameter int BUS_WIDTH = 16
) ();

  logic                 HALT;
  logic                 MEM_READY;
  logic                 EXEC_DONE;
  logic [BUS_WIDTH-1:0] IR_OUTPUT;

  logic PC_ENABLE;
  logic PC_RW;
  logic PC_COUNT;
  logic MAR_ENABLE;
  logic MAR_RW;
  logic MEM_ENABLE;
  logic MEM_RW;
  logic IR_ENABLE;
  logic IR_RW;
  logic OPR_ENABLE;
  logic OPR_RW;

  logic       INSTR_VALID;
  logic       FAULT;
  logic [3:0] STATE;

  modport master (
    input  HALT, MEM_READY, EXEC_DONE, IR_OUTPUT,
    output PC_ENABLE, PC_RW, PC_COUNT,
    output MAR_ENABLE, MAR_RW,
    output MEM_ENABLE, MEM_RW,
    output IR_ENABLE, IR_RW,
    output OPR_ENABLE, OPR_RW,
    output INSTR_VALID, FAULT, STATE
  );

  modport slave (
    output HALT, MEM_READY, EXEC_DONE, IR_OUTPUT,
    input  PC_ENABLE, PC_RW, PC_COUNT,
    input  MAR_ENABLE, MAR_RW,
    input  MEM_ENABLE, MEM_RW,
    input  IR_ENABLE, IR_RW,
    input  OPR_ENABLE, OPR_RW,
    input  INSTR_VALID, FAULT, STATE
  );

endinterface

// File: rtl/bat_fetch_sequencer_wait_timer.sv
// Saturating memory-wait counter; expires at LIMIT.
// Ports: i_clk, i_rst_n (sync), i_clear, i_inc, o_expired.
import bat_fetch_sequencer_pkg::*;

module bat_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] MAXV = '1;
  localparam logic [TIMER_W-1:0] LIM =
    TIMER_W'(LIMIT);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAXV)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= LIM);

endmodule

// File: rtl/bat_fetch_sequencer.sv
// Instruction-fetch control: sequences PC/MAR/MEM/IR/OPR strobes.
// Ports: CLOCK, RESET (sync, active-low), bus (master modport).
import bat_fetch_sequencer_pkg::*;

module bat_fetch_sequencer #(
  parameter int BUS_WIDTH   = 16,
  parameter int OPERAND_BIT = 15,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  bat_fetch_sequencer_if.master bus
);

  state_e r_state;
  state_e w_next;
  logic   w_expired;
  logic   w_clear;
  logic   w_inc;
  logic   w_has_opr;
  logic   w_unused;

  assign w_has_opr = bus.IR_OUTPUT[OPERAND_BIT];
  assign w_unused  = ^bus.IR_OUTPUT[BUS_WIDTH-1:0];

  // Timer restarts on any state change so each read
  // phase gets its own full wait budget.
  assign w_clear = (w_next != r_state);
  assign w_inc   = is_read(r_state) && !bus.MEM_READY;

  bat_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .i_clk     (CLOCK),
    .i_rst_n   (RESET),
    .i_clear   (w_clear),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state <= ST_HALTED;
    end else begin
      r_state <= w_next;
    end
  end

  assign bus.STATE = r_state;

  always_comb begin
    w_next          = r_state;
    bus.PC_ENABLE   = 1'b0;
    bus.PC_RW       = 1'b0;
    bus.PC_COUNT    = 1'b0;
    bus.MAR_ENABLE  = 1'b0;
    bus.MAR_RW      = 1'b0;
    bus.MEM_ENABLE  = 1'b0;
    bus.MEM_RW      = 1'b0;
    bus.IR_ENABLE   = 1'b0;
    bus.IR_RW       = 1'b0;
    bus.OPR_ENABLE  = 1'b0;
    bus.OPR_RW      = 1'b0;
    bus.INSTR_VALID = 1'b0;
    bus.FAULT       = 1'b0;

    unique case (r_state)
      ST_HALTED: begin
        if (!bus.HALT) w_next = ST_ADDR;
      end

      ST_ADDR, ST_OP_ADDR: begin
        bus.PC_ENABLE  = 1'b1;
        bus.PC_RW      = BUS_DRIVE;
        bus.MAR_ENABLE = 1'b1;
        bus.MAR_RW     = BUS_LOAD;
        w_next = (r_state == ST_ADDR) ?
                 ST_READ : ST_OP_READ;
      end

      ST_READ, ST_OP_READ: begin
        bus.MEM_ENABLE = 1'b1;
        bus.MEM_RW     = BUS_DRIVE;
        // Capture and PC bump happen in the
        // same cycle memory presents its data.
        if (bus.MEM_READY) begin
          bus.PC_COUNT = 1'b1;
          if (r_state == ST_READ) begin
            bus.IR_ENABLE = 1'b1;
            bus.IR_RW     = BUS_LOAD;
            w_next        = ST_DECODE;
          end else begin
            bus.OPR_ENABLE = 1'b1;
            bus.OPR_RW     = BUS_LOAD;
            w_next         = ST_EXEC;
          end
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end

      ST_DECODE: begin
        w_next = w_has_opr ? ST_OP_ADDR : ST_EXEC;
      end

      ST_EXEC: begin
        bus.INSTR_VALID = 1'b1;
        if (bus.EXEC_DONE) begin
          w_next = bus.HALT ? ST_HALTED : ST_ADDR;
        end
      end

      ST_FAULT: begin
        bus.FAULT = 1'b1;
      end

      default: begin
        w_next = ST_HALTED;
      end
    endcase
  end

endmodule

// File: tb/tb_bat_fetch_sequencer.sv
// Self-checking bench for bat_fetch_sequencer.
// Directed cycle steps with a queue of expected output vectors.
module tb_bat_fetch_sequencer;

  localparam int S_HALT = 0;
  localparam int S_ADDR = 1;
  localparam int S_READ = 2;
  localparam int S_DEC  = 3;
  localparam int S_OPA  = 4;
  localparam int S_OPR  = 5;
  localparam int S_EXEC = 6;
  localparam int S_FLT  = 7;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  always #5 CLOCK = ~CLOCK;

  bat_fetch_sequencer_if #(.BUS_WIDTH(16)) bus ();

  bat_fetch_sequencer #(
    .BUS_WIDTH   (16),
    .OPERAND_BIT (15),
    .MEM_TIMEOUT (4)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_overlap = 0;

  logic [16:0] q_exp[$];
  string       q_tag[$];

  // Layout: STATE, PC_E, PC_RW, PC_C, MAR_E, MAR_RW,
  // MEM_E, MEM_RW, IR_E, IR_RW, OPR_E, OPR_RW, VALID, FAULT
  function automatic logic [16:0] expv(
    input int st, input logic rdy
  );
    logic pe, prw, pc, me, mrw, ne, nrw;
    logic ie, irw, oe, orw, v, f;
    {pe, prw, pc, me, mrw, ne, nrw} = '0;
    {ie, irw, oe, orw, v, f} = '0;
    case (st)
      S_ADDR, S_OPA: begin
        pe = 1; prw = 1; me = 1; mrw = 0;
      end
      S_READ: begin
        ne = 1; nrw = 1;
        if (rdy) begin ie = 1; irw = 0; pc = 1; end
      end
      S_OPR: begin
        ne = 1; nrw = 1;
        if (rdy) begin oe = 1; orw = 0; pc = 1; end
      end
      S_EXEC: v = 1;
      S_FLT:  f = 1;
      default: ;
    endcase
    return {4'(st), pe, prw, pc, me, mrw, ne, nrw,
            ie, irw, oe, orw, v, f};
  endfunction

  function automatic logic [16:0] obsv();
    return {bus.STATE,
            bus.PC_ENABLE, bus.PC_RW, bus.PC_COUNT,
            bus.MAR_ENABLE, bus.MAR_RW,
            bus.MEM_ENABLE, bus.MEM_RW,
            bus.IR_ENABLE, bus.IR_RW,
            bus.OPR_ENABLE, bus.OPR_RW,
            bus.INSTR_VALID, bus.FAULT};
  endfunction

  task automatic check_out();
    logic [16:0] e;
    logic [16:0] o;
    string       t;
    n_cmp++;
    if (q_exp.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %h expected entry",
             obsv());
    end else begin
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      o = obsv();
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic cyc(
    input int st, input logic halt, input logic rdy,
    input logic done, input logic [15:0] ir,
    input string tag
  );
    bus.HALT      = halt;
    bus.MEM_READY = rdy;
    bus.EXEC_DONE = done;
    bus.IR_OUTPUT = ir;
    q_exp.push_back(expv(st, rdy));
    q_tag.push_back(tag);
    @(negedge CLOCK);
    check_out();
    @(posedge CLOCK);
    #1;
  endtask

  // Count cycles where more than one unit drives the bus.
  always @(negedge CLOCK) begin
    if (RESET) begin
      if ($countones({bus.PC_ENABLE & bus.PC_RW,
                      bus.MAR_ENABLE & bus.MAR_RW,
                      bus.MEM_ENABLE & bus.MEM_RW,
                      bus.IR_ENABLE & bus.IR_RW,
                      bus.OPR_ENABLE & bus.OPR_RW}) > 1)
        n_overlap++;
    end
  end

  initial begin
    bus.HALT      = 1'b1;
    bus.MEM_READY = 1'b0;
    bus.EXEC_DONE = 1'b0;
    bus.IR_OUTPUT = 16'h0000;
    RESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b1;

    cyc(S_HALT, 1, 0, 0, 16'h0000, "rst_hold");
    cyc(S_HALT, 0, 1, 0, 16'h0012, "rst_release");

    cyc(S_ADDR, 0, 1, 0, 16'h0012, "s1_c0_addr");
    cyc(S_READ, 0, 1, 0, 16'h0012, "s1_c1_read");
    cyc(S_DEC,  0, 1, 0, 16'h0012, "s1_c2_dec");
    cyc(S_EXEC, 0, 1, 0, 16'h0012, "s1_c3_exec");
    cyc(S_EXEC, 0, 1, 0, 16'h0012, "s1_c4_exec");
    cyc(S_EXEC, 0, 1, 1, 16'h0012, "s1_c5_done");

    cyc(S_ADDR, 0, 1, 0, 16'h8012, "s2_c0_addr");
    cyc(S_READ, 0, 1, 0, 16'h8012, "s2_c1_read");
    cyc(S_DEC,  0, 1, 0, 16'h8012, "s2_c2_dec");
    cyc(S_OPA,  0, 1, 0, 16'h8012, "s2_c3_opaddr");
    cyc(S_OPR,  0, 1, 0, 16'h8012, "s2_c4_opread");
    cyc(S_EXEC, 0, 1, 1, 16'h8012, "s2_c5_exec");

    cyc(S_ADDR, 0, 0, 0, 16'h0012, "s3_c0_addr");
    cyc(S_READ, 0, 0, 0, 16'h0012, "s3_c1_wait");
    cyc(S_READ, 0, 0, 1, 16'h0012, "s3_c2_wait");
    cyc(S_READ, 0, 0, 0, 16'h0012, "s3_c3_wait");
    cyc(S_READ, 0, 1, 0, 16'h0012, "s3_c4_read");
    cyc(S_DEC,  0, 1, 0, 16'h0012, "s3_c5_dec");
    cyc(S_EXEC, 0, 1, 1, 16'h0012, "s3_c6_exec");

    cyc(S_ADDR, 0, 1, 0, 16'h0012, "h_addr");
    cyc(S_READ, 1, 1, 0, 16'h0012, "h_read");
    cyc(S_DEC,  1, 1, 0, 16'h0012, "h_dec");
    cyc(S_EXEC, 1, 1, 0, 16'h0012, "h_exec");
    cyc(S_EXEC, 1, 1, 1, 16'h0012, "h_done");
    cyc(S_HALT, 1, 1, 0, 16'h0012, "h_halted");
    cyc(S_HALT, 0, 1, 1, 16'h0012, "h_release");

    cyc(S_ADDR, 0, 1, 0, 16'h8012, "r_addr");
    cyc(S_READ, 0, 1, 0, 16'h8012, "r_read");
    cyc(S_DEC,  0, 1, 0, 16'h8012, "r_dec");
    cyc(S_OPA,  0, 1, 0, 16'h8012, "r_opaddr");
    RESET = 1'b0;
    cyc(S_OPR,  0, 0, 0, 16'h8012, "r_opread");
    RESET = 1'b1;
    cyc(S_HALT, 1, 1, 0, 16'h8012, "r_after");
    cyc(S_HALT, 0, 0, 0, 16'h0012, "r_release");

    cyc(S_ADDR, 0, 0, 0, 16'h0012, "t_addr");
    for (int i = 0; i < 5; i++)
      cyc(S_READ, 0, 0, 0, 16'h0012,
          $sformatf("t_wait%0d", i));
    cyc(S_FLT, 0, 1, 0, 16'h0012, "t_fault0");
    cyc(S_FLT, 0, 1, 1, 16'h0012, "t_fault1");
    cyc(S_FLT, 1, 0, 0, 16'h0012, "t_fault2");
    RESET = 1'b0;
    cyc(S_FLT, 0, 0, 0, 16'h0012, "t_rst_cyc");
    RESET = 1'b1;
    cyc(S_HALT, 1, 0, 0, 16'h0012, "t_halted");
    cyc(S_HALT, 0, 1, 0, 16'h0012, "t_release");
    cyc(S_ADDR, 0, 1, 0, 16'h0012, "t_refetch");

    n_cmp++;
    assert (n_overlap === 0) else begin
      n_bad++;
      $error("FAIL bus_overlap: observed %0d expected 0",
             n_overlap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
